traffic_input_stage: RTL and testbench
======================================

Name: traffic_input_stage

Overview:
Front-end stage that feeds the traffic-light sequencer. It conditions the two raw vehicle-sensor inputs: 2-flop synchronisation, debounce, and a sticky request latch that holds until the sequencer acknowledges it. It also generates the single-cycle 1 Hz tick and a saturating seconds counter that the sequencer uses for phase timing. All outputs are synchronous to the system clock; no derived clocks.

Parameters:
TICK_DIV, 50000000, clk cycles per tick period (1 s at 50 MHz); must be >= 2
DEBOUNCE_CYCLES, 500000, cycles a synchronised input must hold a new level before it is accepted (10 ms at 50 MHz); must be >= 1
SEC_W, 4, width of seconds counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
s0_raw  input  1  main-road vehicle sensor, asynchronous, may bounce
s1_raw  input  1  side-road vehicle sensor, asynchronous, may bounce
ack0  input  1  sequencer clears req0 (level, sampled each cycle)
ack1  input  1  sequencer clears req1
clr_sec  input  1  synchronous clear of sec_count
s0_clean  output  1  debounced s0 level
s1_clean  output  1  debounced s1 level
req0  output  1  latched main-road request
req1  output  1  latched side-road request
tick  output  1  one-cycle pulse every TICK_DIV cycles
sec_count  output  SEC_W  ticks since last clear, saturating

Behaviour:
- Reset (async assert, release synchronous to clk): synchroniser flops, debounce counters, clean levels, req0/1, divider, tick and sec_count all 0. Reset mid-operation discards pending debounce and requests.
- Synchroniser: two flops per sensor. The sync output lags the raw input by 2 cycles.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If sync == clean: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: clean <= sync, counter <= 0.
  - Else: counter++.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes clean. A clean raw step reaches s*_clean after 2 + DEBOUNCE_CYCLES cycles.
- Request latch, per channel:
  - Rising edge of clean (registered previous value 0, current 1) sets req on the next cycle.
  - ack high clears req.
  - Set and ack in the same cycle: set wins and req stays 1, so a new arrival is never lost.
  - ack with req=0 has no effect.
  - A falling edge of clean does not touch req.
- Tick divider: counter runs 0..TICK_DIV-1 and wraps to 0. tick = 1 for exactly the cycle the counter equals TICK_DIV-1. The first tick occurs at cycle TICK_DIV-1 after reset release, then every TICK_DIV cycles. The divider is free-running and unaffected by clr_sec.
- sec_count:
  - On tick: increments, saturating at 2^SEC_W-1 (no wrap).
  - clr_sec: sets it to 0 on the next edge.
  - clr_sec and tick in the same cycle: clear wins, result 0.
- Channels are fully independent. Simultaneous events on s0/s1 are handled in parallel with no priority.
- Registered outputs only; no combinational path from any input to any output.

Test Plan:
All scenarios use TICK_DIV=10, DEBOUNCE_CYCLES=4.
1. Reset then idle 35 cycles -> tick high at cycles 9, 19, 29 only. sec_count reads 1, 2, 3 after each tick. All other outputs remain 0.
2. s0_raw 0->1 held -> s0_clean rises 6 cycles after the edge. req0 rises 1 cycle later and stays 1 after s0_raw returns to 0. Pulse ack0 for 1 cycle -> req0 = 0 next cycle.
3. s1_raw pulses of 1, 2 and 3 cycles separated by 5 low cycles -> s1_clean and req1 remain 0 throughout. A 4-cycle-stable pulse -> s1_clean = 1.
4. Hold ack0 = 1 continuously while a new s0 debounced rising edge occurs -> req0 = 1 for the set cycle (set wins). It drops on the following cycle once ack0 is still high and no new edge occurs.
5. Run 170 cycles without clr_sec -> sec_count saturates at 15 and stays 15. Assert clr_sec on the same cycle as a tick -> sec_count = 0, then 1 after the next tick.
6. Assert rst asynchronously mid-debounce with req1 = 1 and sec_count = 7 -> all outputs 0 immediately, without waiting for clk. After release, the divider restarts with the first tick at cycle 9.

Source files
------------

// File: rtl/traffic_input_stage.sv
// -----------------------------------------------------------------------------
// traffic_input_stage
//
// Front end of the traffic-light sequencer. Conditions the two raw vehicle
// sensors (2-flop synchroniser, debounce, sticky request latch) and generates
// the 1 Hz timebase (single-cycle tick plus a saturating seconds counter).
// Everything runs on clk; there are no derived clocks and every output is
// driven straight from a flop.
//
// Parameters:
//   TICK_DIV        clk cycles per tick period (>= 2)
//   DEBOUNCE_CYCLES cycles a synchronised level must persist before acceptance (>= 1)
//   SEC_W           width of the seconds counter
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   s0_raw     main-road sensor, asynchronous, may bounce
//   s1_raw     side-road sensor, asynchronous, may bounce
//   ack0/ack1  sequencer acknowledge, clears the matching request (level)
//   clr_sec    synchronous clear of sec_count
//   s0_clean   debounced s0 level
//   s1_clean   debounced s1 level
//   req0/req1  latched requests, held until acknowledged
//   tick       one-cycle pulse every TICK_DIV cycles
//   sec_count  ticks since last clear, saturating
// -----------------------------------------------------------------------------
module traffic_input_stage #(
   parameter int unsigned TICK_DIV        = 50000000,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned SEC_W           = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s0_raw,
   input  logic             s1_raw,
   input  logic             ack0,
   input  logic             ack1,
   input  logic             clr_sec,
   output logic             s0_clean,
   output logic             s1_clean,
   output logic             req0,
   output logic             req1,
   output logic             tick,
   output logic [SEC_W-1:0] sec_count
);

   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned DIV_W = $clog2(TICK_DIV);

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [SEC_W-1:0] SEC_MAX  = '1;

   // Channel 0 is the main road, channel 1 the side road.
   logic [1:0] raw;
   logic [1:0] ack;

   assign raw = {s1_raw, s0_raw};
   assign ack = {ack1, ack0};

   // ---------------------------------------------------------------------------
   // Sensor conditioning state
   // ---------------------------------------------------------------------------
   logic [1:0]            sync1_q;
   logic [1:0]            sync2_q;
   logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [1:0]            clean_q, clean_d;
   logic [1:0]            clean_prev_q;
   logic [1:0]            req_q, req_d;
   logic [1:0]            rise;

   // ---------------------------------------------------------------------------
   // Timebase state
   // ---------------------------------------------------------------------------
   logic [DIV_W-1:0]      div_q, div_d;
   logic                  tick_q, tick_d;
   logic [SEC_W-1:0]      sec_q, sec_d;

   // Debounce: the counter measures how long the synchronised level has
   // disagreed with the accepted level; any agreement restarts the count, so a
   // glitch shorter than DEBOUNCE_CYCLES never gets through.
   always_comb begin
      clean_d  = clean_q;
      db_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != clean_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               clean_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Request latch: a new debounced arrival takes priority over an ack in the
   // same cycle so that no arrival is lost; falling edges are ignored.
   assign rise  = clean_q & ~clean_prev_q;
   assign req_d = rise | (req_q & ~ack);

   // Free-running divider; tick is registered from the next divider value so
   // it lines up with the cycle in which the divider sits at TICK_DIV-1.
   always_comb begin
      if (div_q == DIV_LAST) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
      tick_d = (div_d == DIV_LAST);
   end

   // Seconds counter: clear beats a coincident tick; saturates, never wraps.
   always_comb begin
      sec_d = sec_q;
      if (clr_sec) begin
         sec_d = '0;
      end else if (tick_q && (sec_q != SEC_MAX)) begin
         sec_d = sec_q + SEC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         db_cnt_q     <= '0;
         clean_q      <= '0;
         clean_prev_q <= '0;
         req_q        <= '0;
         div_q        <= '0;
         tick_q       <= 1'b0;
         sec_q        <= '0;
      end else begin
         sync1_q      <= raw;
         sync2_q      <= sync1_q;
         db_cnt_q     <= db_cnt_d;
         clean_q      <= clean_d;
         clean_prev_q <= clean_q;
         req_q        <= req_d;
         div_q        <= div_d;
         tick_q       <= tick_d;
         sec_q        <= sec_d;
      end
   end

   assign s0_clean  = clean_q[0];
   assign s1_clean  = clean_q[1];
   assign req0      = req_q[0];
   assign req1      = req_q[1];
   assign tick      = tick_q;
   assign sec_count = sec_q;

endmodule

// File: tb/tb_traffic_input_stage.sv
module tb_traffic_input_stage;

   localparam int unsigned TD    = 10;
   localparam int unsigned DB    = 4;
   localparam int unsigned SEC_W = 4;

   logic             clk;
   logic             rst;
   logic             s0_raw, s1_raw, ack0, ack1, clr_sec;
   logic             s0_clean, s1_clean, req0, req1, tick;
   logic [SEC_W-1:0] sec_count;

   traffic_input_stage #(
      .TICK_DIV        (TD),
      .DEBOUNCE_CYCLES (DB),
      .SEC_W           (SEC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s0_raw    (s0_raw),
      .s1_raw    (s1_raw),
      .ack0      (ack0),
      .ack1      (ack1),
      .clr_sec   (clr_sec),
      .s0_clean  (s0_clean),
      .s1_clean  (s1_clean),
      .req0      (req0),
      .req1      (req1),
      .tick      (tick),
      .sec_count (sec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {s0_clean, s1_clean, req0, req1, tick, sec_count}
   logic [8:0] obs;
   assign obs = {s0_clean, s1_clean, req0, req1, tick, sec_count};

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;

   logic [8:0] sb_q[$];

   // Reference model state, written from the behavioural description.
   logic [1:0] m_s1, m_s2, m_clean, m_prev, m_req;
   int         m_cnt[2];
   int         m_div;
   logic       m_tick;
   int         m_sec;

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_checks++;
      assert (o === e) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_prev = '0; m_req = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_div = 0; m_tick = 1'b0; m_sec = 0;
   endtask

   function automatic logic [8:0] model_vec();
      return {m_clean[0], m_clean[1], m_req[0], m_req[1], m_tick, 4'(m_sec)};
   endfunction

   task automatic model_step(input logic r0, input logic r1, input logic a0, input logic a1,
                             input logic clr);
      logic [1:0] n_clean, n_req;
      int         n_cnt[2];
      int         n_div, n_sec;
      logic [1:0] a;
      a = {a1, a0};
      for (int i = 0; i < 2; i++) begin
         n_clean[i] = m_clean[i];
         n_cnt[i]   = 0;
         if (m_s2[i] != m_clean[i]) begin
            if (m_cnt[i] + 1 >= DB) n_clean[i] = m_s2[i];
            else n_cnt[i] = m_cnt[i] + 1;
         end
         if (m_clean[i] && !m_prev[i]) n_req[i] = 1'b1;
         else if (a[i])                n_req[i] = 1'b0;
         else                          n_req[i] = m_req[i];
      end
      n_div = (m_div + 1) % TD;
      if (clr)                        n_sec = 0;
      else if (m_tick && m_sec < 15)  n_sec = m_sec + 1;
      else                            n_sec = m_sec;
      m_prev  = m_clean;
      m_s2    = m_s1;
      m_s1    = {r1, r0};
      m_clean = n_clean;
      m_cnt   = n_cnt;
      m_req   = n_req;
      m_tick  = (n_div == TD - 1);
      m_div   = n_div;
      m_sec   = n_sec;
   endtask

   // One clock: drive at a falling edge, push the model's prediction, then
   // pop and compare at the next falling edge.
   task automatic cyc(input logic r0, input logic r1, input logic a0, input logic a1,
                      input logic clr);
      logic [8:0] e;
      s0_raw = r0; s1_raw = r1; ack0 = a0; ack1 = a1; clr_sec = clr;
      model_step(r0, r1, a0, a1, clr);
      sb_q.push_back(model_vec());
      @(negedge clk);
      cycle++;
      e = sb_q.pop_front();
      check($sformatf("model_c%0d", cycle), 32'(obs), 32'(e));
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle = 0;
      check("after_release", 32'(obs), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi_cnt;
      logic found;

      rst = 1'b1; s0_raw = 0; s1_raw = 0; ack0 = 0; ack1 = 0; clr_sec = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_hold", 32'(obs), 32'd0);
      release_reset();

      // Idle: ticks at 9, 19, 29; seconds follow.
      for (int i = 0; i < 35; i++) begin
         cyc(0, 0, 0, 0, 0);
         check($sformatf("idle_tick_c%0d", cycle), 32'(tick),
               32'(cycle == 9 || cycle == 19 || cycle == 29));
         if (cycle == 10) check("sec_1", 32'(sec_count), 32'd1);
         if (cycle == 20) check("sec_2", 32'(sec_count), 32'd2);
         if (cycle == 30) check("sec_3", 32'(sec_count), 32'd3);
      end

      // s0 step: clean after 6, request one later, sticky, ack clears.
      for (int k = 1; k <= 8; k++) begin
         cyc(1, 0, 0, 0, 0);
         if (k == 5) check("s0_clean_not_yet", 32'(s0_clean), 32'd0);
         if (k == 6) check("s0_clean_at_6", 32'(s0_clean), 32'd1);
         if (k == 6) check("req0_not_yet", 32'(req0), 32'd0);
         if (k == 7) check("req0_at_7", 32'(req0), 32'd1);
      end
      repeat (3) cyc(0, 0, 0, 0, 0);
      check("req0_sticky", 32'(req0), 32'd1);
      cyc(0, 0, 1, 0, 0);
      check("ack0_clear", 32'(req0), 32'd0);
      repeat (6) cyc(0, 0, 0, 0, 0);
      check("s0_fall", 32'(s0_clean), 32'd0);
      check("req0_fall_no_set", 32'(req0), 32'd0);

      // s1 glitches of 1, 2, 3 cycles are rejected.
      for (int n = 1; n <= 3; n++) begin
         for (int k = 0; k < n + 5; k++) begin
            cyc(0, (k < n), 0, 0, 0);
            check($sformatf("glitch%0d_clean", n), 32'(s1_clean), 32'd0);
            check($sformatf("glitch%0d_req", n), 32'(req1), 32'd0);
         end
      end
      // A 4-cycle pulse is accepted.
      for (int k = 1; k <= 7; k++) begin
         cyc(0, (k <= 4), 0, 0, 0);
         if (k == 6) check("pulse4_clean", 32'(s1_clean), 32'd1);
         if (k == 7) check("pulse4_req", 32'(req1), 32'd1);
      end
      repeat (8) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      check("ack1_clear", 32'(req1), 32'd0);

      // ack0 held while a new s0 arrival happens: req0 high exactly one cycle.
      hi_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         cyc(1, 0, 1, 0, 0);
         if (req0) hi_cnt++;
         if (k == 7) check("set_wins", 32'(req0), 32'd1);
         if (k == 8) check("ack_after_set", 32'(req0), 32'd0);
      end
      check("set_wins_width", 32'(hi_cnt), 32'd1);
      repeat (8) cyc(0, 0, 1, 0, 0);

      // Saturation and clear-on-tick.
      repeat (170) cyc(0, 0, 0, 0, 0);
      check("sec_sat", 32'(sec_count), 32'd15);
      repeat (10) cyc(0, 0, 0, 0, 0);
      check("sec_sat_hold", 32'(sec_count), 32'd15);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (tick) found = 1'b1;
         else cyc(0, 0, 0, 0, 0);
      end
      check("tick_found", 32'(found), 32'd1);
      cyc(0, 0, 0, 0, 1);
      check("clr_beats_tick", 32'(sec_count), 32'd0);
      repeat (9) cyc(0, 0, 0, 0, 0);
      check("next_tick", 32'(tick), 32'd1);
      check("sec_before_inc", 32'(sec_count), 32'd0);
      cyc(0, 0, 0, 0, 0);
      check("sec_after_clr_tick", 32'(sec_count), 32'd1);

      // Async reset mid-operation.
      rst = 1'b1;
      release_reset();
      while (cycle < 70) cyc(0, 1, 0, 0, 0);
      check("pre_rst_sec7", 32'(sec_count), 32'd7);
      check("pre_rst_req1", 32'(req1), 32'd1);
      repeat (3) cyc(1, 1, 0, 0, 0);
      #2;
      rst = 1'b1;
      s0_raw = 0; s1_raw = 0;
      model_reset();
      #1;
      check("async_rst_now", 32'(obs), 32'd0);
      @(negedge clk);
      release_reset();
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 0, 0, 0);
         check($sformatf("post_rst_tick_c%0d", cycle), 32'(tick), 32'(cycle == 9));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
